// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: sequences an N-byte burst through a mode-0 SPI byte transceiver.
// Ports: cmd_* burst request; tx_* byte stream in; rx_* byte stream out;
//   busy/done/err_* burst status; spi_start/spi_end/data_send drive the
//   transceiver; data_rec/send_done/rec_done/spi_cs come back from it.
module spi_burst_ctrl #(
   parameter int         LEN_W   = 8,
   parameter logic [7:0] FILL    = 8'hFF,
   parameter int         TIMEOUT = 1024
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [7:0]       tx_data,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   output logic             rx_last,
   output logic             busy,
   output logic             done,
   output logic             err_underflow,
   output logic             err_timeout,
   output logic             spi_start,
   output logic             spi_end,
   output logic [7:0]       data_send,
   input  logic [7:0]       data_rec,
   input  logic             send_done,
   input  logic             rec_done,
   input  logic             spi_cs
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      IDLE, FETCH, START, XFER, ENDP, WAIT_CS, DONE
   } state_t;

   state_t state, state_n;

   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] sent;
   logic [LEN_W-1:0] rcvd;
   logic [LEN_W-1:0] fetched;
   logic [7:0]       nxt;
   logic             nxt_full;
   logic [TW-1:0]    tcnt;

   logic tx_take;
   logic evt;
   logic counting;
   logic to_hit;
   logic last_send;
   logic mid_send;
   logic rec_ok;

   assign tx_take = tx_valid && tx_ready;

   // Any transceiver event restarts the watchdog, so a timeout
   // never fires in the same cycle as a real event.
   always_comb begin
      evt       = send_done || rec_done;
      counting  = (state == START) || (state == XFER) ||
                  (state == WAIT_CS);
      to_hit    = counting && !evt &&
                  (tcnt == TW'(TIMEOUT - 1));
      last_send = (state == XFER) && send_done &&
                  (sent == len - LEN_W'(1));
      mid_send  = (state == XFER) && send_done &&
                  (sent != len - LEN_W'(1));
      rec_ok    = (state != IDLE) && rec_done && (rcvd != len);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:
            if (cmd_valid)
               state_n = (cmd_len == '0) ? DONE : FETCH;
         FETCH:
            if (tx_valid) state_n = START;
         START:
            state_n = to_hit ? DONE : XFER;
         XFER:
            if (to_hit)         state_n = DONE;
            else if (last_send) state_n = ENDP;
         ENDP:
            state_n = WAIT_CS;
         WAIT_CS:
            if (to_hit)                      state_n = DONE;
            else if (spi_cs && rcvd == len)  state_n = DONE;
         DONE:
            state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   // In WAIT_CS the end pulse has already gone out, so a
   // timeout there only aborts.
   always_comb begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      done      = (state == DONE);
      spi_start = (state == START);
      spi_end   = (state == ENDP) ||
                  (to_hit && state != WAIT_CS);
      tx_ready  = (state == FETCH) ||
                  ((state == XFER) && !nxt_full && (fetched < len));
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         len           <= '0;
         sent          <= '0;
         rcvd          <= '0;
         fetched       <= '0;
         nxt           <= '0;
         nxt_full      <= 1'b0;
         tcnt          <= '0;
         data_send     <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_last       <= 1'b0;
         err_underflow <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_last  <= 1'b0;

         if (state == IDLE && cmd_valid) begin
            len           <= cmd_len;
            sent          <= '0;
            rcvd          <= '0;
            fetched       <= '0;
            nxt_full      <= 1'b0;
            err_underflow <= 1'b0;
            err_timeout   <= 1'b0;
         end

         if (state == FETCH && tx_valid) begin
            data_send <= tx_data;
            fetched   <= LEN_W'(1);
         end

         if (state == XFER && tx_take)
            fetched <= fetched + LEN_W'(1);
         if (state == XFER && send_done)
            sent <= sent + LEN_W'(1);

         // A byte arriving on the very cycle it is needed goes
         // straight out instead of being replaced by FILL.
         if (mid_send) begin
            if (nxt_full) begin
               data_send <= nxt;
               nxt_full  <= 1'b0;
            end else if (tx_take) begin
               data_send <= tx_data;
            end else begin
               data_send     <= FILL;
               err_underflow <= 1'b1;
            end
         end else if (state == XFER && tx_take) begin
            nxt      <= tx_data;
            nxt_full <= 1'b1;
         end

         if (to_hit) begin
            err_timeout <= 1'b1;
            nxt_full    <= 1'b0;
         end

         if (rec_ok) begin
            rx_data  <= data_rec;
            rx_valid <= 1'b1;
            rx_last  <= (rcvd == len - LEN_W'(1));
            rcvd     <= rcvd + LEN_W'(1);
         end

         if (!counting || evt || state_n != state)
            tcnt <= '0;
         else
            tcnt <= tcnt + TW'(1);
      end
   end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: randomized bench with a transceiver loopback model,
// a FIFO reference model of byte slots and a scoreboard monitor.
module tb_spi_burst_ctrl;

   localparam logic [7:0] FILL = 8'hFF;
   localparam int         TO   = 16;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_len   = '0;
   logic       tx_valid  = 1'b0;
   logic       tx_ready;
   logic [7:0] tx_data   = '0;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_last;
   logic       busy;
   logic       done;
   logic       err_underflow;
   logic       err_timeout;
   logic       spi_start;
   logic       spi_end;
   logic [7:0] data_send;
   logic [7:0] data_rec  = '0;
   logic       send_done = 1'b0;
   logic       rec_done  = 1'b0;
   logic       spi_cs    = 1'b1;

   spi_burst_ctrl #(
      .LEN_W  (8),
      .FILL   (FILL),
      .TIMEOUT(TO)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_len      (cmd_len),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_last      (rx_last),
      .busy         (busy),
      .done         (done),
      .err_underflow(err_underflow),
      .err_timeout  (err_timeout),
      .spi_start    (spi_start),
      .spi_end      (spi_end),
      .data_send    (data_send),
      .data_rec     (data_rec),
      .send_done    (send_done),
      .rec_done     (rec_done),
      .spi_cs       (spi_cs)
   );

   always #10 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int         m_len;
   logic [7:0] avail[$];
   logic [7:0] exp_q[$];
   int         loads, sends, rx_idx, n_start, n_end;
   bit         exp_uf, exp_to, done_seen;
   int         cyc, last_evt, end_cyc;
   // transceiver stall control
   bit         stall;
   int         stall_idx;
   // tx stream
   logic [7:0] tx_bytes[$];
   int         tx_pct;
   int         tx_i;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load_slot();
      logic [7:0] b;
      if (avail.size() > 0) b = avail.pop_front();
      else begin
         b = FILL;
         exp_uf = 1'b1;
      end
      exp_q.push_back(b);
      loads++;
   endtask

   task automatic chk_reset_vals(input string nm);
      logic [25:0] v;
      v = {cmd_ready, busy, done, tx_ready, rx_valid, rx_last,
           err_underflow, err_timeout, spi_start, spi_end,
           rx_data, data_send};
      chk(nm, 32'(v), 32'(26'h200_0000));
   endtask

   // Reference model: accepted TX bytes queue up; every byte slot
   // (first FETCH load, then each non-final send_done) takes the
   // oldest queued byte or FILL.
   initial begin
      cyc = 0;
      forever begin
         @(negedge sys_clk);
         #1;
         cyc++;
         if (sys_rst_n) begin
            if (tx_valid && tx_ready) begin
               avail.push_back(tx_data);
               if (loads == 0) load_slot();
            end
            if (send_done) begin
               if (sends + 1 < m_len) load_slot();
               sends++;
               last_evt = cyc;
            end
            if (rec_done) last_evt = cyc;
            if (spi_start) begin
               n_start++;
               last_evt = cyc;
            end
            if (spi_end) begin
               n_end++;
               end_cyc = cyc;
            end
         end
      end
   end

   // Scoreboard monitor
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge sys_clk);
         #1;
         if (sys_rst_n) begin
            if (rx_valid) begin
               if (exp_q.size() == 0) chk("rx_extra", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("rx_data", 32'(rx_data), 32'(e));
                  chk("rx_last", 32'(rx_last),
                      32'(rx_idx == m_len - 1));
               end
               rx_idx++;
            end
            if (done) begin
               chk("err_underflow", 32'(err_underflow), 32'(exp_uf));
               chk("err_timeout", 32'(err_timeout), 32'(exp_to));
               chk("rx_count", rx_idx, exp_to ? stall_idx : m_len);
               chk("n_start", n_start, 32'(m_len > 0));
               chk("n_end", n_end, 32'(m_len > 0));
               if (exp_to) chk("to_latency", end_cyc - last_evt, TO);
               exp_q.delete();
               done_seen = 1'b1;
            end
         end
      end
   end

   // Transceiver model: loops each byte presented on data_send back.
   initial begin
      int st, cnt, idx;
      logic [7:0] cur, pb;
      bit pend;
      st = 0; cnt = 0; idx = 0; cur = '0; pb = '0; pend = 1'b0;
      forever begin
         @(negedge sys_clk);
         send_done = 1'b0;
         rec_done  = 1'b0;
         if (!sys_rst_n) begin
            st = 0;
            pend = 1'b0;
            spi_cs = 1'b1;
         end else begin
            if (pend) begin
               rec_done = 1'b1;
               data_rec = pb;
               pend = 1'b0;
            end
            case (st)
               0: if (spi_start) begin
                  spi_cs = 1'b0;
                  cur = data_send;
                  idx = 0;
                  cnt = $urandom_range(6, 2);
                  st = 1;
               end
               1: if (spi_end) begin
                  cnt = 2;
                  st = 3;
               end else if (!(stall && idx == stall_idx)) begin
                  if (cnt == 0) begin
                     send_done = 1'b1;
                     if ($urandom_range(1, 0) == 1) begin
                        rec_done = 1'b1;
                        data_rec = cur;
                     end else begin
                        pend = 1'b1;
                        pb = cur;
                     end
                     st = 2;
                  end else cnt--;
               end
               2: if (spi_end) begin
                  cnt = 2;
                  st = 3;
               end else begin
                  cur = data_send;
                  idx++;
                  cnt = $urandom_range(6, 2);
                  st = 1;
               end
               3: if (cnt == 0) begin
                  spi_cs = 1'b1;
                  st = 0;
               end else cnt--;
               default: st = 0;
            endcase
         end
      end
   end

   // TX stream driver with random valid gaps
   initial begin
      bit acc;
      acc = 1'b0;
      tx_i = 0;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            tx_valid = 1'b0;
            acc = 1'b0;
         end else begin
            if (acc) tx_i++;
            if (tx_i < tx_bytes.size() &&
                $urandom_range(99, 0) < tx_pct) begin
               tx_valid = 1'b1;
               tx_data  = tx_bytes[tx_i];
            end else tx_valid = 1'b0;
            #1 acc = tx_valid && tx_ready;
         end
      end
   end

   task automatic start_burst(input int len, input int pct,
                              input bit stl, input int sidx);
      bit rdy;
      rdy = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         if (cmd_ready) begin
            rdy = 1'b1;
            break;
         end
      end
      if (!rdy) chk("cmd_ready_wait", 0, 1);
      m_len = len;
      avail.delete();
      exp_q.delete();
      loads = 0; sends = 0; rx_idx = 0; n_start = 0; n_end = 0;
      exp_uf = 1'b0; exp_to = stl; done_seen = 1'b0;
      stall = stl; stall_idx = sidx;
      tx_i = 0; tx_pct = pct;
      cmd_valid = 1'b1;
      cmd_len = 8'(len);
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      if (len == 0) begin
         #1;
         chk("len0_done", 32'(done), 1);
         chk("len0_cmd_ready_low", 32'(cmd_ready), 0);
         @(negedge sys_clk);
         #1;
         chk("len0_cmd_ready_back", 32'(cmd_ready), 1);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000; i++) begin
         if (done_seen) break;
         @(negedge sys_clk);
      end
      if (!done_seen) chk("done_wait", 0, 1);
   endtask

   task automatic run_burst(input int len, input int pct,
                            input bit stl, input int sidx);
      start_burst(len, pct, stl, sidx);
      wait_done();
   endtask

   task automatic rand_bytes(input int n);
      tx_bytes.delete();
      for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      bit seen;
      repeat (3) @(negedge sys_clk);
      #1 chk_reset_vals("reset_values");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      tx_bytes = '{8'hA5};
      run_burst(1, 100, 1'b0, 0);

      tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_burst(4, 100, 1'b0, 0);

      tx_bytes = '{8'h3C};
      run_burst(3, 100, 1'b0, 0);

      tx_bytes.delete();
      run_burst(0, 100, 1'b0, 0);

      rand_bytes(4);
      run_burst(4, 100, 1'b1, 2);
      rand_bytes(3);
      run_burst(3, 100, 1'b0, 0);

      rand_bytes(4);
      start_burst(4, 100, 1'b0, 0);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge sys_clk);
         #2;
         if (sends >= 1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("reached_byte2", 32'(seen), 1);
      #3 sys_rst_n = 1'b0;
      #1 chk_reset_vals("async_reset");
      exp_q.delete();
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      rand_bytes(4);
      run_burst(4, 100, 1'b0, 0);

      for (int k = 0; k < 10; k++) begin
         len = $urandom_range(10, 1);
         if (k % 3 == 0) rand_bytes($urandom_range(len, 1));
         else rand_bytes(len);
         run_burst(len, $urandom_range(100, 40), k == 5,
                   $urandom_range(len - 1, 0));
      end

      repeat (4) @(negedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
Transaction sequencer that sits directly upstream of the mode-0 SPI byte transceiver. It accepts a burst command of N bytes and a byte stream of TX data, then drives the transceiver's start, end and data_send controls. It collects each received byte into an RX stream and reports burst completion, TX underflow and timeout.

Parameters:
LEN_W, 8, width of burst length (1..2^LEN_W-1 bytes)
FILL, 8'hFF, byte sent when TX data is not available in time
TIMEOUT, 1024, sys_clk cycles allowed between transceiver events before abort

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high in IDLE only
cmd_len  in  LEN_W  bytes in the burst
tx_valid  in  1  TX byte valid
tx_ready  out  1  controller accepts TX byte this cycle
tx_data  in  8  TX byte, MSB sent first
rx_valid  out  1  one-cycle pulse, rx_data valid
rx_data  out  8  received byte
rx_last  out  1  qualifies rx_valid for the final byte of the burst
busy  out  1  high from command accept until done
done  out  1  one-cycle pulse at burst end
err_underflow  out  1  sticky per burst; FILL was substituted at least once
err_timeout  out  1  valid with done; burst aborted
spi_start  out  1  one-cycle pulse to transceiver
spi_end  out  1  one-cycle pulse to transceiver
data_send  out  8  byte presented to transceiver
data_rec  in  8  transceiver receive byte
send_done  in  1  transceiver pulse: last bit of byte shifted out
rec_done  in  1  transceiver pulse: byte received; data_rec is valid that cycle
spi_cs  in  1  transceiver chip-select level, monitored

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State=IDLE. Counters and holding register cleared.
- Clock/reset: single clock sys_clk; reset sys_rst_n is asynchronous and active-low.
- States: IDLE, FETCH, START, XFER, ENDP, WAIT_CS, DONE.
- IDLE: cmd_valid&&cmd_ready latches len, clears err flags and counters, sets busy.
  - len==0: go to DONE; no SPI activity.
  - Otherwise: go to FETCH.
- FETCH: tx_ready=1. On tx_valid, data_send<=tx_data, then go to START. FETCH waits indefinitely; there is no timeout here.
- START: spi_start=1 for exactly one cycle, then go to XFER.
- XFER:
  - Prefetch: a 1-deep next register nxt. tx_ready=1 while nxt is empty and fetched<len. Accepting a byte fills nxt.
  - On send_done with sent+1<len: data_send<=nxt and nxt is emptied. If nxt was empty, data_send<=FILL and err_underflow<=1. sent is incremented.
  - On send_done with sent+1==len: go to ENDP.
- ENDP: spi_end=1 for one cycle, asserted the cycle after the final send_done, then go to WAIT_CS.
- WAIT_CS: when spi_cs==1 and rcvd==len, go to DONE.
- DONE: done=1 for one cycle, busy falls, then go to IDLE.
- RX path (any non-IDLE state):
  - On rec_done, register rx_data<=data_rec and pulse rx_valid in the following cycle; latency is 1.
  - rx_last=1 when rcvd+1==len. rcvd is incremented.
  - rec_done beyond len is ignored.
- A rec_done and a send_done in the same cycle are both serviced.
- data_send is held stable except on the cycle after send_done or the FETCH load.
- Timeout: a counter runs in START, XFER and WAIT_CS. It clears on any send_done, rec_done or state change. Reaching TIMEOUT-1 does the following:
  - spi_end pulses once, unless already issued.
  - err_timeout<=1.
  - State goes to DONE; the done pulse carries err_timeout=1.
  - nxt is discarded.
- Counters are LEN_W bits wide and never wrap, since len is at most 2^LEN_W-1.
- Reset mid-burst returns everything to reset values immediately. The transceiver is reset by the same sys_rst_n.

Test Plan:
1. cmd_len=1, tx_data=8'hA5, transceiver model loops MOSI->MISO -> one spi_start, spi_end one cycle after send_done, rx_valid with rx_data=8'hA5 and rx_last=1, done with no errors.
2. cmd_len=4, tx bytes 01,02,03,04 always valid -> data_send sequence 01..04, each change one cycle after send_done, rx 01..04, rx_last only on 04, exactly one spi_start and one spi_end.
3. cmd_len=3, tx_valid withheld after first byte -> bytes sent 8'hxx,FF,FF; err_underflow=1 at done.
4. cmd_len=0 -> done pulse 1 cycle after accept; spi_start never asserted; cmd_ready=0 for exactly 1 cycle.
5. Transceiver stalls (no send_done) with TIMEOUT=16 -> spi_end pulses 16 cycles after the last event; done with err_timeout=1; next command succeeds normally.
6. sys_rst_n asserted mid-byte 2 of 4 -> all outputs return to reset values asynchronously; a new command after release completes cleanly.
